// File: rtl/chip8_pkg.sv
// Shared Chip-8 CPU types: op encodings for the stack, ALU and PC mux, and the return-stack depth.
package chip8_pkg;

    localparam int STACK_DEPTH = 16;

    typedef enum logic [1:0] {
        STACK_HOLD = 2'd0,
        STACK_PUSH = 2'd1,
        STACK_POP  = 2'd2
    } STACK_OP;

    typedef enum logic [3:0] {
        ALU_MOV = 4'd0,
        ALU_OR  = 4'd1,
        ALU_AND = 4'd2,
        ALU_XOR = 4'd3,
        ALU_ADD = 4'd4,
        ALU_SUB = 4'd5,
        ALU_SHR = 4'd6,
        ALU_SBN = 4'd7,
        ALU_SHL = 4'd14
    } ALU_OP;

    typedef enum logic [1:0] {
        PC_NEXT = 2'd0,
        PC_SKIP = 2'd1,
        PC_JUMP = 2'd2,
        PC_RET  = 2'd3
    } PC_SEL;

endpackage

// File: rtl/chip8_stack_ram.sv
// Return-stack register file: one synchronous write port, one combinational read port.
// Latency: write visible on the read port the edge after we; read is same-cycle.
// Backpressure: none; synchronous clear zeroes every entry.
module chip8_stack_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     cpu_clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/chip8_stack.sv
// Chip-8 subroutine-return stack: CALL pushes the return PC, RET pops it onto outdata.
// Latency: popped value on outdata one edge after POP; overflow pushes dropped, underflow pops give 0.
// Backpressure: none. CHIP8_STACK_STATUS_EN adds full/empty/sticky error outputs.
module chip8_stack
    import chip8_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int WIDTH = 16
) (
    input  logic             cpu_clk,
    input  logic             reset,
    input  STACK_OP          op,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] outdata
`ifdef CHIP8_STACK_STATUS_EN
    ,
    output logic             full,
    output logic             empty,
    output logic             error
`endif
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    logic [SPW-1:0]   sp;
    logic             is_full;
    logic             is_empty;
    logic             push_ok;
    logic             pop_ok;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;

    assign is_full  = (sp == SPW'(DEPTH));
    assign is_empty = (sp == '0);
    assign push_ok  = (op == STACK_PUSH) && !is_full;
    assign pop_ok   = (op == STACK_POP) && !is_empty;
    // sp points one past the top; the top entry lives at sp-1.
    assign raddr    = AW'(sp - SPW'(1));

    chip8_stack_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .cpu_clk (cpu_clk),
        .reset   (reset),
        .we      (push_ok),
        .waddr   (sp[AW-1:0]),
        .wdata   (writedata),
        .raddr   (raddr),
        .rdata   (rdata)
    );

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            sp      <= '0;
            outdata <= '0;
        end else if (push_ok) begin
            sp <= sp + SPW'(1);
        end else if (op == STACK_POP) begin
            if (pop_ok) begin
                outdata <= rdata;
                sp      <= sp - SPW'(1);
            end else begin
                outdata <= '0;
            end
        end
    end

`ifdef CHIP8_STACK_STATUS_EN
    assign full  = is_full;
    assign empty = is_empty;

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            error <= 1'b0;
        end else if (((op == STACK_PUSH) && is_full) || ((op == STACK_POP) && is_empty)) begin
            error <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_chip8_stack.sv
// Directed bench for chip8_stack: LIFO order, overflow/underflow, reset priority, undefined op.
module tb_chip8_stack;
    import chip8_pkg::*;

    logic        cpu_clk = 1'b0;
    logic        reset;
    STACK_OP     op;
    logic [15:0] writedata;
    logic [15:0] outdata;
`ifdef CHIP8_STACK_STATUS_EN
    logic        full;
    logic        empty;
    logic        error;
`endif

    int checks = 0;
    int errors = 0;

    always #5 cpu_clk = ~cpu_clk;

    chip8_stack dut (
        .cpu_clk   (cpu_clk),
        .reset     (reset),
        .op        (op),
        .writedata (writedata),
        .outdata   (outdata)
`ifdef CHIP8_STACK_STATUS_EN
        ,
        .full      (full),
        .empty     (empty),
        .error     (error)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive op/data for one edge, then settle 1 time unit past it.
    task automatic tick(input STACK_OP o, input logic [15:0] d);
        op        = o;
        writedata = d;
        @(posedge cpu_clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        op        = STACK_HOLD;
        writedata = 16'h0000;
        @(posedge cpu_clk);
        #1;
        reset = 1'b0;
        check("reset_outdata", 32'(outdata), 32'h0);
        check("reset_sp", 32'(dut.sp), 32'd0);
`ifdef CHIP8_STACK_STATUS_EN
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_error", 32'(error), 32'd0);
`endif

        for (int i = 0; i < 6; i++) tick(STACK_PUSH, 16'h00FF);
        check("push6_sp", 32'(dut.sp), 32'd6);
        tick(STACK_HOLD, 16'hDEAD);
        tick(STACK_HOLD, 16'hDEAD);
        tick(STACK_PUSH, 16'h0066);
        tick(STACK_PUSH, 16'h0066);
        check("push8_sp", 32'(dut.sp), 32'd8);
        check("push8_outdata", 32'(outdata), 32'h0);

        tick(STACK_POP, 16'h0); check("pop1", 32'(outdata), 32'h0066);
        tick(STACK_POP, 16'h0); check("pop2", 32'(outdata), 32'h0066);
        tick(STACK_POP, 16'h0); check("pop3", 32'(outdata), 32'h00FF);
        tick(STACK_POP, 16'h0); check("pop4", 32'(outdata), 32'h00FF);
        tick(STACK_POP, 16'h0); check("pop5", 32'(outdata), 32'h00FF);
        check("pop5_sp", 32'(dut.sp), 32'd3);

        for (int i = 0; i < 5; i++) tick(STACK_HOLD, 16'h1111);
        check("hold_outdata", 32'(outdata), 32'h00FF);
        check("hold_sp", 32'(dut.sp), 32'd3);

        tick(STACK_POP, 16'h0); check("drain1", 32'(outdata), 32'h00FF);
        tick(STACK_POP, 16'h0); check("drain2", 32'(outdata), 32'h00FF);
        tick(STACK_POP, 16'h0); check("drain3", 32'(outdata), 32'h00FF);
        check("drain3_sp", 32'(dut.sp), 32'd0);
        tick(STACK_POP, 16'h0); check("under1", 32'(outdata), 32'h0);
        tick(STACK_POP, 16'h0); check("under2", 32'(outdata), 32'h0);
        check("under_sp", 32'(dut.sp), 32'd0);
`ifdef CHIP8_STACK_STATUS_EN
        check("under_error", 32'(error), 32'd1);
`endif

        // Undefined op encoding must leave state alone.
        tick(STACK_PUSH, 16'h0ABC);
        tick(STACK_OP'(2'd3), 16'h0DEF);
        check("undef_sp", 32'(dut.sp), 32'd1);
        tick(STACK_POP, 16'h0);
        check("undef_pop", 32'(outdata), 32'h0ABC);

        reset = 1'b1;
        tick(STACK_HOLD, 16'h0);
        reset = 1'b0;
`ifdef CHIP8_STACK_STATUS_EN
        check("reset2_error", 32'(error), 32'd0);
`endif
        for (int i = 0; i < 16; i++) tick(STACK_PUSH, 16'h0200 + 16'(i));
        check("fill_sp", 32'(dut.sp), 32'd16);
`ifdef CHIP8_STACK_STATUS_EN
        check("fill_full", 32'(full), 32'd1);
        check("fill_error", 32'(error), 32'd0);
`endif
        tick(STACK_PUSH, 16'h0210);
        check("over_sp", 32'(dut.sp), 32'd16);
        check("over_outdata", 32'(outdata), 32'h0);
`ifdef CHIP8_STACK_STATUS_EN
        check("over_error", 32'(error), 32'd1);
`endif
        for (int i = 15; i >= 0; i--) begin
            tick(STACK_POP, 16'h0);
            check($sformatf("lifo%0d", i), 32'(outdata), 32'h0200 + 32'(i));
        end
        check("lifo_sp", 32'(dut.sp), 32'd0);

        tick(STACK_PUSH, 16'h0300);
        tick(STACK_PUSH, 16'h0301);
        reset = 1'b1;
        tick(STACK_PUSH, 16'h1234);
        reset = 1'b0;
        check("midreset_sp", 32'(dut.sp), 32'd0);
        check("midreset_outdata", 32'(outdata), 32'h0);
        tick(STACK_POP, 16'h0);
        check("midreset_pop", 32'(outdata), 32'h0);
        check("midreset_pop_sp", 32'(dut.sp), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
